// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Round-robin picker: first requesting index after last_gnt_i, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_gnt_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // Offsets run 1..NUM_REQ so last_gnt_i itself is considered last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IW'((32'(last_gnt_i) + off) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to a single-outstanding data memory port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned FETCH_WIDTH = 64,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_rd_en_i,
  input  logic [NUM_REQ-1:0]                          req_wr_en_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]               req_addr_i,
  input  logic [NUM_REQ*$clog2(FETCH_WIDTH/8)-1:0]    req_wr_size_i,
  input  logic [NUM_REQ*FETCH_WIDTH-1:0]              req_wr_data_i,
  output logic [NUM_REQ-1:0]                          req_gnt_o,
  output logic [NUM_REQ-1:0]                          req_rdy_o,
  output logic [NUM_REQ-1:0]                          req_err_o,
  output logic [FETCH_WIDTH-1:0]                      req_rd_data_o,
  input  logic                                        dmem_busy_i,
  input  logic                                        dmem_rdy_i,
  input  logic [FETCH_WIDTH-1:0]                      dmem_rd_data_i,
  output logic                                        dmem_rd_en_o,
  output logic                                        dmem_wr_en_o,
  output logic [DATA_WIDTH-1:0]                       dmem_addr_o,
  output logic [$clog2(FETCH_WIDTH/8)-1:0]            dmem_wr_size_o,
  output logic [FETCH_WIDTH-1:0]                      dmem_wr_data_o
);

  localparam int unsigned SW = $clog2(FETCH_WIDTH / 8);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           last_q, last_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [SW-1:0]           size_q, size_d;
  logic [FETCH_WIDTH-1:0]  wdata_q, wdata_d;

  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic                    sel_rd, sel_wr;
  logic [DATA_WIDTH-1:0]   sel_addr;
  logic [SW-1:0]           sel_size;
  logic [FETCH_WIDTH-1:0]  sel_wdata;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req_i      (req_rd_en_i | req_wr_en_i),
    .last_gnt_i (last_q),
    .valid_o    (pick_valid),
    .idx_o      (pick_idx)
  );

  assign sel_rd    = req_rd_en_i[pick_idx];
  assign sel_wr    = req_wr_en_i[pick_idx];
  assign sel_addr  = req_addr_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_size  = req_wr_size_i[pick_idx*SW +: SW];
  assign sel_wdata = req_wr_data_i[pick_idx*FETCH_WIDTH +: FETCH_WIDTH];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    idx_d          = idx_q;
    addr_d         = addr_q;
    size_d         = size_q;
    wdata_d        = wdata_q;
    req_gnt_o      = '0;
    req_rdy_o      = '0;
    req_err_o      = '0;
    req_rd_data_o  = '0;
    dmem_rd_en_o   = 1'b0;
    dmem_wr_en_o   = 1'b0;
    dmem_addr_o    = '0;
    dmem_wr_size_o = '0;
    dmem_wr_data_o = '0;

    unique case (state_q)
      IDLE: begin
        if (!dmem_busy_i && pick_valid) begin
          req_gnt_o[pick_idx] = 1'b1;
          if (sel_rd && sel_wr) begin
            req_err_o[pick_idx] = 1'b1;
            last_d              = pick_idx;
          end else begin
            dmem_rd_en_o   = sel_rd;
            dmem_wr_en_o   = sel_wr;
            dmem_addr_o    = sel_addr;
            dmem_wr_size_o = sel_size;
            dmem_wr_data_o = sel_wdata;
            addr_d         = sel_addr;
            size_d         = sel_size;
            wdata_d        = sel_wdata;
            idx_d          = pick_idx;
            cnt_d          = '0;
            state_d        = WAIT;
          end
        end
      end
      WAIT: begin
        dmem_addr_o    = addr_q;
        dmem_wr_size_o = size_q;
        dmem_wr_data_o = wdata_q;
        // Completion takes priority over a coincident timeout.
        if (dmem_rdy_i) begin
          req_rdy_o[idx_q] = 1'b1;
          req_rd_data_o    = dmem_rd_data_i;
          last_d           = idx_q;
          cnt_d            = '0;
          state_d          = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_err_o[idx_q] = 1'b1;
          last_d           = idx_q;
          cnt_d            = '0;
          state_d          = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet while rst is low so an abandoned WAIT never pulses.
    if (!rst) begin
      req_gnt_o      = '0;
      req_rdy_o      = '0;
      req_err_o      = '0;
      req_rd_data_o  = '0;
      dmem_rd_en_o   = 1'b0;
      dmem_wr_en_o   = 1'b0;
      dmem_addr_o    = '0;
      dmem_wr_size_o = '0;
      dmem_wr_data_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      idx_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
